// File: rtl/rf_write_queue_pkg.sv
// Shared register-file constants and types used by the deferred write queue.
// The widths match the 32x32 register file this queue feeds.
package rf_write_queue_pkg;

    localparam int XLEN       = 32;
    localparam int REG_ADDR_W = 5;
    localparam int NUM_REGS   = 32;

    typedef logic [XLEN-1:0]       xlen_t;
    typedef logic [REG_ADDR_W-1:0] reg_addr_t;

    // One-hot register select, used to build the pending-write scoreboard.
    function automatic logic [NUM_REGS-1:0] reg_onehot(input reg_addr_t addr);
        return NUM_REGS'(1) << addr;
    endfunction

endpackage

// File: rtl/rf_write_queue_match.sv
// Youngest-match lookup over the queue entries for one forwarding read address.
// Walks from the oldest entry (head) to the youngest so the last match wins.
module wbq_match
    import rf_write_queue_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic [DEPTH-1:0]                 valid_i,
    input  logic [DEPTH-1:0][REG_ADDR_W-1:0] addr_i,
    input  logic [DEPTH-1:0][XLEN-1:0]       data_i,
    input  logic [$clog2(DEPTH)-1:0]         head_i,
    input  logic [REG_ADDR_W-1:0]            raddr_i,
    output logic                             hit_o,
    output logic [XLEN-1:0]                  data_o
);

    localparam int IDX_W = $clog2(DEPTH);

    logic [IDX_W-1:0] idx;

    // Register x0 is hard-wired to zero, so it can never be forwarded.
    always_comb begin
        hit_o  = 1'b0;
        data_o = '0;
        idx    = '0;
        for (int k = 0; k < DEPTH; k++) begin
            idx = head_i + IDX_W'(k);
            if ((raddr_i != '0) && valid_i[idx] && (addr_i[idx] == raddr_i)) begin
                hit_o  = 1'b1;
                data_o = data_i[idx];
            end
        end
    end

endmodule

// File: rtl/rf_write_queue.sv
// Deferred register-file write queue: buffers late writes, drains one per free
// port cycle, and exports a pending scoreboard plus youngest-entry forwarding.
module rf_write_queue
    import rf_write_queue_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_valid,
    output logic                  o_ready,
    input  logic [REG_ADDR_W-1:0] i_waddr,
    input  logic [XLEN-1:0]       i_wdata,
    input  logic                  i_port_busy,
    output logic                  o_rd_wen,
    output logic [REG_ADDR_W-1:0] o_rd_waddr,
    output logic [XLEN-1:0]       o_rd_wdata,
    output logic [NUM_REGS-1:0]   o_busy,
    input  logic [REG_ADDR_W-1:0] i_rs1_raddr,
    output logic                  o_rs1_hit,
    output logic [XLEN-1:0]       o_rs1_fwd,
    input  logic [REG_ADDR_W-1:0] i_rs2_raddr,
    output logic                  o_rs2_hit,
    output logic [XLEN-1:0]       o_rs2_fwd
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int PTR_W = IDX_W + 1;

    logic [PTR_W-1:0]                 head_q, head_d;
    logic [PTR_W-1:0]                 tail_q, tail_d;
    logic [DEPTH-1:0]                 valid_q, valid_d;
    logic [DEPTH-1:0][REG_ADDR_W-1:0] addr_q, addr_d;
    logic [DEPTH-1:0][XLEN-1:0]       data_q, data_d;

    logic [IDX_W-1:0]    headIdx;
    logic [IDX_W-1:0]    tailIdx;
    logic                empty;
    logic                full;
    logic                store;
    logic                drain;
    logic [NUM_REGS-1:0] busy;

    assign headIdx = head_q[IDX_W-1:0];
    assign tailIdx = tail_q[IDX_W-1:0];

    // The extra pointer MSB tells a full queue apart from an empty one.
    assign empty = (head_q == tail_q);
    assign full  = (head_q[PTR_W-1] != tail_q[PTR_W-1]) &&
                   (head_q[IDX_W-1:0] == tail_q[IDX_W-1:0]);

    // Writes to x0 complete the handshake but occupy no slot.
    assign store = i_valid && !full && (i_waddr != '0);
    assign drain = !empty && !i_port_busy;

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        valid_d = valid_q;
        addr_d  = addr_q;
        data_d  = data_q;
        if (store) begin
            valid_d[tailIdx] = 1'b1;
            addr_d[tailIdx]  = i_waddr;
            data_d[tailIdx]  = i_wdata;
            tail_d           = tail_q + PTR_W'(1);
        end
        if (drain) begin
            valid_d[headIdx] = 1'b0;
            head_d           = head_q + PTR_W'(1);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            valid_q <= '0;
            addr_q  <= '0;
            data_q  <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            valid_q <= valid_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
        end
    end

    assign o_ready    = !full;
    assign o_rd_wen   = drain;
    assign o_rd_waddr = drain ? addr_q[headIdx] : '0;
    assign o_rd_wdata = drain ? data_q[headIdx] : '0;

    always_comb begin
        busy = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (valid_q[i]) begin
                busy = busy | reg_onehot(addr_q[i]);
            end
        end
        busy[0] = 1'b0;
    end

    assign o_busy = busy;

    wbq_match #(.DEPTH(DEPTH)) u_match_rs1 (
        .valid_i (valid_q),
        .addr_i  (addr_q),
        .data_i  (data_q),
        .head_i  (headIdx),
        .raddr_i (i_rs1_raddr),
        .hit_o   (o_rs1_hit),
        .data_o  (o_rs1_fwd)
    );

    wbq_match #(.DEPTH(DEPTH)) u_match_rs2 (
        .valid_i (valid_q),
        .addr_i  (addr_q),
        .data_i  (data_q),
        .head_i  (headIdx),
        .raddr_i (i_rs2_raddr),
        .hit_o   (o_rs2_hit),
        .data_o  (o_rs2_fwd)
    );

endmodule

// File: tb/tb_rf_write_queue.sv
// Directed bench for rf_write_queue: reset, drain latency, backpressure, forwarding,
// x0 writes and pointer wrap, with RF writes logged against hand-computed values.
module tb_rf_write_queue;

    logic        i_clk;
    logic        i_rst;
    logic        i_valid;
    logic        o_ready;
    logic [4:0]  i_waddr;
    logic [31:0] i_wdata;
    logic        i_port_busy;
    logic        o_rd_wen;
    logic [4:0]  o_rd_waddr;
    logic [31:0] o_rd_wdata;
    logic [31:0] o_busy;
    logic [4:0]  i_rs1_raddr;
    logic        o_rs1_hit;
    logic [31:0] o_rs1_fwd;
    logic [4:0]  i_rs2_raddr;
    logic        o_rs2_hit;
    logic [31:0] o_rs2_fwd;

    int errorCount = 0;
    int checkCount = 0;

    logic [31:0] rfModel [32];
    logic [4:0]  logAddr [$];
    logic [31:0] logData [$];
    logic [4:0]  expAddr [$];
    logic [31:0] expData [$];

    rf_write_queue #(.DEPTH(4)) dut (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_valid     (i_valid),
        .o_ready     (o_ready),
        .i_waddr     (i_waddr),
        .i_wdata     (i_wdata),
        .i_port_busy (i_port_busy),
        .o_rd_wen    (o_rd_wen),
        .o_rd_waddr  (o_rd_waddr),
        .o_rd_wdata  (o_rd_wdata),
        .o_busy      (o_busy),
        .i_rs1_raddr (i_rs1_raddr),
        .o_rs1_hit   (o_rs1_hit),
        .o_rs1_fwd   (o_rs1_fwd),
        .i_rs2_raddr (i_rs2_raddr),
        .o_rs2_hit   (o_rs2_hit),
        .o_rs2_fwd   (o_rs2_fwd)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
        end
    endtask

    // Log any RF write happening on the coming edge, then move 1ns past it.
    task automatic applyStimulus();
        #1;
        if (o_rd_wen) begin
            logAddr.push_back(o_rd_waddr);
            logData.push_back(o_rd_wdata);
            rfModel[o_rd_waddr] = o_rd_wdata;
        end
        @(posedge i_clk);
        #1;
    endtask

    initial begin
        bit accepted;
        for (int r = 0; r < 32; r++) rfModel[r] = '0;
        i_rst = 1'b1;
        i_valid = 1'b0;
        i_waddr = '0;
        i_wdata = '0;
        i_port_busy = 1'b0;
        i_rs1_raddr = '0;
        i_rs2_raddr = '0;
        applyStimulus();
        applyStimulus();
        i_rst = 1'b0;
        #1;
        checkOutput("rst_ready", 32'(o_ready), 32'd1);
        checkOutput("rst_wen", 32'(o_rd_wen), 32'd0);
        checkOutput("rst_busy", o_busy, 32'd0);
        checkOutput("rst_waddr", 32'(o_rd_waddr), 32'd0);
        checkOutput("rst_wdata", o_rd_wdata, 32'd0);
        checkOutput("rst_hit", 32'(o_rs1_hit), 32'd0);

        // Reset in the middle of a fill discards every queued entry.
        i_port_busy = 1'b1;
        i_valid = 1'b1;
        for (int r = 1; r <= 3; r++) begin
            i_waddr = 5'(r);
            i_wdata = 32'h50 + 32'(r);
            applyStimulus();
        end
        i_valid = 1'b0;
        #1;
        checkOutput("fill_busy", o_busy, 32'h0000_000E);
        i_rst = 1'b1;
        applyStimulus();
        i_rst = 1'b0;
        i_port_busy = 1'b0;
        #1;
        checkOutput("midrst_busy", o_busy, 32'd0);
        checkOutput("midrst_wen", 32'(o_rd_wen), 32'd0);
        checkOutput("midrst_ready", 32'(o_ready), 32'd1);

        // Single write: no bypass, drains the cycle after enqueue.
        i_valid = 1'b1;
        i_waddr = 5'd5;
        i_wdata = 32'hA5A5_A5A5;
        #1;
        checkOutput("nobypass_wen", 32'(o_rd_wen), 32'd0);
        applyStimulus();
        i_valid = 1'b0;
        #1;
        checkOutput("single_wen", 32'(o_rd_wen), 32'd1);
        checkOutput("single_waddr", 32'(o_rd_waddr), 32'd5);
        checkOutput("single_wdata", o_rd_wdata, 32'hA5A5_A5A5);
        checkOutput("single_busy5", o_busy, 32'h0000_0020);
        applyStimulus();
        checkOutput("single_busy_clr", o_busy, 32'd0);
        checkOutput("single_wen_off", 32'(o_rd_wen), 32'd0);

        // Port held busy: queue fills, fifth write waits, drain order preserved.
        i_port_busy = 1'b1;
        i_valid = 1'b1;
        for (int r = 1; r <= 4; r++) begin
            i_waddr = 5'(r);
            i_wdata = 32'h100 + 32'(r);
            applyStimulus();
        end
        i_waddr = 5'd9;
        i_wdata = 32'h999;
        #1;
        checkOutput("full_ready", 32'(o_ready), 32'd0);
        checkOutput("full_busy", o_busy, 32'h0000_001E);
        applyStimulus();
        checkOutput("held_ready", 32'(o_ready), 32'd0);
        i_port_busy = 1'b0;
        for (int r = 1; r <= 4; r++) begin
            #1;
            checkOutput("drain_wen", 32'(o_rd_wen), 32'd1);
            checkOutput("drain_waddr", 32'(o_rd_waddr), 32'(r));
            checkOutput("drain_wdata", o_rd_wdata, 32'h100 + 32'(r));
            if (r == 1) checkOutput("drain_ready_full", 32'(o_ready), 32'd0);
            if (r == 2) checkOutput("drain_ready_free", 32'(o_ready), 32'd1);
            applyStimulus();
            if (r == 2) i_valid = 1'b0;
        end
        #1;
        checkOutput("fifth_waddr", 32'(o_rd_waddr), 32'd9);
        checkOutput("fifth_wdata", o_rd_wdata, 32'h999);
        applyStimulus();
        checkOutput("fifth_empty", 32'(o_rd_wen), 32'd0);

        // Same register twice: forwarding returns the younger value.
        i_port_busy = 1'b1;
        i_valid = 1'b1;
        i_waddr = 5'd7;
        i_wdata = 32'h11;
        applyStimulus();
        i_wdata = 32'h22;
        applyStimulus();
        i_valid = 1'b0;
        i_rs1_raddr = 5'd7;
        i_rs2_raddr = 5'd8;
        #1;
        checkOutput("fwd_rs1_hit", 32'(o_rs1_hit), 32'd1);
        checkOutput("fwd_rs1_data", o_rs1_fwd, 32'h22);
        checkOutput("fwd_rs2_miss", 32'(o_rs2_hit), 32'd0);
        checkOutput("fwd_rs2_zero", o_rs2_fwd, 32'd0);
        i_rs2_raddr = 5'd7;
        #1;
        checkOutput("fwd_rs2_data", o_rs2_fwd, 32'h22);
        i_port_busy = 1'b0;
        #1;
        checkOutput("fwd_while_drain", o_rs1_fwd, 32'h22);
        checkOutput("drain_old_first", o_rd_wdata, 32'h11);
        applyStimulus();
        applyStimulus();
        checkOutput("rf_x7", rfModel[7], 32'h22);
        checkOutput("fwd_after_drain", 32'(o_rs1_hit), 32'd0);

        // x0 write: accepted but never stored or forwarded.
        i_rs1_raddr = 5'd0;
        i_valid = 1'b1;
        i_waddr = 5'd0;
        i_wdata = 32'hFFFF_FFFF;
        #1;
        checkOutput("x0_ready", 32'(o_ready), 32'd1);
        applyStimulus();
        i_valid = 1'b0;
        #1;
        checkOutput("x0_wen", 32'(o_rd_wen), 32'd0);
        checkOutput("x0_busy", o_busy, 32'd0);
        checkOutput("x0_hit", 32'(o_rs1_hit), 32'd0);

        // Wrap: ten writes through a four-entry queue with random port contention.
        logAddr.delete();
        logData.delete();
        for (int i = 0; i < 10; i++) begin
            i_valid = 1'b1;
            i_waddr = 5'(10 + i);
            i_wdata = 32'hC0DE_0000 + 32'(i);
            expAddr.push_back(5'(10 + i));
            expData.push_back(32'hC0DE_0000 + 32'(i));
            accepted = 1'b0;
            for (int c = 0; c < 50 && !accepted; c++) begin
                i_port_busy = 1'($urandom_range(0, 1));
                #1;
                accepted = o_ready;
                applyStimulus();
            end
            if (!accepted) checkOutput("wrap_enq_timeout", 32'd1, 32'd0);
        end
        i_valid = 1'b0;
        i_port_busy = 1'b0;
        for (int c = 0; c < 20; c++) begin
            #1;
            if (!o_rd_wen) break;
            applyStimulus();
        end
        checkOutput("wrap_count", 32'(logAddr.size()), 32'd10);
        for (int i = 0; i < 10; i++) begin
            if (i < logAddr.size()) begin
                checkOutput("wrap_addr", 32'(logAddr[i]), 32'(expAddr[i]));
                checkOutput("wrap_data", logData[i], expData[i]);
            end
        end
        checkOutput("wrap_busy_end", o_busy, 32'd0);

        $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
        $finish;
    end

endmodule
